writeback_arbiter: RTL and testbench

- Final pipeline stage directly upstream of the 32x32 register file.
- Merges two result sources onto the register file's single write port:
  - the in-order pipeline writeback, which is never stalled;
  - a multicycle multiply/divide unit, which uses a valid/ready handshake and is buffered in a small FIFO.
- Drops writes to register 0.
- Requests a pipeline stall when buffered results are starved for too long.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/writeback_arbiter.sv | 147 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// The optional pending-register mask is enabled by defining WB_PENDING_MASK_EN.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer of multdiv results awaiting the register-file write port.
// With WB_PENDING_MASK_EN defined, the storage array and per-slot valid flags are exposed.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  wb_req_t                push_req,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
`ifdef WB_PENDING_MASK_EN
  ,
  output wb_req_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]       occupied
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t [DEPTH-1:0] mem;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap for free.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

`ifdef WB_PENDING_MASK_EN
  // Push and pop never target the same slot: that would need an empty pop or a full push.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      occupied <= '0;
    end else begin
      if (pop) begin
        occupied[rd_ptr] <= 1'b0;
      end
      if (push) begin
        occupied[wr_ptr] <= 1'b1;
      end
    end
  end

  assign entries = mem;
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline writeback and buffered multdiv results onto the single register-file write port.
// Define WB_PENDING_MASK_EN to add the pending_mask output for hazard logic.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clock,
  input  logic                   ctrl_reset_n,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   md_valid,
  output logic                   md_ready,
  input  logic [REG_ADDR_W-1:0]  md_reg,
  input  logic [DATA_W-1:0]      md_data,
  output logic                   ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0]      data_writeReg,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [31:0]            pending_mask
`endif
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic       primary;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  wb_req_t    head;
  logic [7:0] starve;
  logic [7:0] starve_next;
  arb_state_t state;
  arb_state_t state_next;

`ifdef WB_PENDING_MASK_EN
  wb_req_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]    occupied;
`endif

  // Register 0 is hard-wired, so writes to it are neither issued nor buffered.
  assign primary  = wb_valid && (wb_reg != 5'd0);
  assign md_ready = !full;
  assign push     = md_valid && !full && (md_reg != 5'd0);
  assign pop      = !primary && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (ctrl_reset_n),
    .push     (push),
    .push_req ('{rd: md_reg, data: md_data}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty)
`ifdef WB_PENDING_MASK_EN
    ,
    .entries  (entries),
    .occupied (occupied)
`endif
  );

  // Write port register: address and data hold when nothing is issued.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else if (primary) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= wb_reg;
      data_writeReg    <= wb_data;
    end else if (pop) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= head.rd;
      data_writeReg    <= head.data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  // A non-empty FIFO that does not pop has, by construction, lost to the primary source.
  always_comb begin
    starve_next = starve;
    if (empty || pop) begin
      starve_next = 8'd0;
    end else if (starve != STARVE_LIM) begin
      starve_next = starve + 8'd1;
    end else begin
      starve_next = starve;
    end
  end

  // Stall is entered on a saturated starve count and held until the FIFO has fully drained.
  always_comb begin
    state_next = state;
    case (state)
      NORMAL: begin
        if (starve == STARVE_LIM) begin
          state_next = STALL;
        end else begin
          state_next = NORMAL;
        end
      end
      STALL: begin
        if (fifo_count == '0) begin
          state_next = NORMAL;
        end else begin
          state_next = STALL;
        end
      end
      default: state_next = NORMAL;
    endcase
  end

  // Starve counter, arbitration state and the registered stall request.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      starve    <= 8'd0;
      state     <= NORMAL;
      stall_req <= 1'b0;
    end else begin
      starve    <= starve_next;
      state     <= state_next;
      stall_req <= (state_next == STALL);
    end
  end

`ifdef WB_PENDING_MASK_EN
  // One bit per destination register still waiting in the FIFO.
  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_mask[entries[i].rd] = pending_mask[entries[i].rd] | occupied[i];
    end
    pending_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: stimulus queues expected writes and status snapshots,
// a negedge monitor pops and compares them.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall_req;
  logic [2:0]  fifo_count;
`ifdef WB_PENDING_MASK_EN
  logic [31:0] pending_mask;
`endif

  always #5 clock = ~clock;

  writeback_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .wb_valid         (wb_valid),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_reg           (md_reg),
    .md_data          (md_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .stall_req        (stall_req),
    .fifo_count       (fifo_count)
`ifdef WB_PENDING_MASK_EN
    ,
    .pending_mask     (pending_mask)
`endif
  );

  typedef struct packed {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct packed {
    int          cyc;
    logic [2:0]  cnt;
    logic        rdy;
    logic        stall;
    logic        we;
    logic        chk_wd;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_mask;
    logic [31:0] mask;
  } st_exp_t;

  wr_exp_t     wr_q[$];
  st_exp_t     st_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          done = 1'b0;
  logic [4:0]  rr [3] = '{5'd4, 5'd9, 5'd4};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, got, want);
    end
  endtask

  // Monitor: compares every write-port event and every status snapshot due this cycle.
  always @(negedge clock) begin
    wr_exp_t w;
    st_exp_t s;
    if (ctrl_writeEnable === 1'b1) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write cyc=%0d got reg=%0d data=0x%0h want no write",
                 cyc, ctrl_writeReg, data_writeReg);
      end else begin
        w = wr_q.pop_front();
        check("write_reg", 32'(ctrl_writeReg), 32'(w.rd));
        check("write_data", data_writeReg, w.data);
        check("write_cycle", cyc, w.cyc);
      end
    end
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      s = st_q.pop_front();
      if (s.cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL status_missed got cyc=%0d want cyc=%0d", cyc, s.cyc);
      end else begin
        check("fifo_count", 32'(fifo_count), 32'(s.cnt));
        check("md_ready", 32'(md_ready), 32'(s.rdy));
        check("stall_req", 32'(stall_req), 32'(s.stall));
        check("write_enable", 32'(ctrl_writeEnable), 32'(s.we));
        if (s.chk_wd) begin
          check("write_reg_state", 32'(ctrl_writeReg), 32'(s.rd));
          check("write_data_state", data_writeReg, s.data);
        end
`ifdef WB_PENDING_MASK_EN
        if (s.chk_mask) begin
          check("pending_mask", pending_mask, s.mask);
        end
`endif
      end
    end
    if (done) begin
      check("writes_outstanding", wr_q.size(), 32'd0);
      check("status_outstanding", st_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d want finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_wr(input int c, input logic [4:0] r, input logic [31:0] d);
    wr_exp_t w;
    w.cyc  = c;
    w.rd   = r;
    w.data = d;
    wr_q.push_back(w);
  endtask

  // Snapshot expected at the negedge of the current cycle.
  task automatic exp_st(input logic [2:0] cnt, input logic rdy, input logic stall, input logic we,
                        input logic chk_wd, input logic [4:0] r, input logic [31:0] d,
                        input logic chk_mask, input logic [31:0] mask);
    st_exp_t s;
    s.cyc = cyc;   s.cnt = cnt;       s.rdy = rdy; s.stall = stall; s.we = we;
    s.chk_wd = chk_wd; s.rd = r;      s.data = d;  s.chk_mask = chk_mask; s.mask = mask;
    st_q.push_back(s);
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
    tick();
    tick();
    ctrl_reset_n = 1'b1;
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 32'd0);
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 32'd0);

    // Primary write, one cycle latency, then idle with address/data held.
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEAD_BEEF;
    exp_wr(cyc + 1, 5'd5, 32'hDEAD_BEEF);
    tick();
    wb_valid = 1'b0;
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'd0);

    // Primary to register 0 is dropped.
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h0BAD_0BAD;
    tick();
    wb_valid = 1'b0;
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'd0);

    // Multdiv idle path: two-cycle latency through the FIFO.
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h12;
    exp_wr(cyc + 2, 5'd7, 32'h12);
    tick();
    md_valid = 1'b0;
    exp_st(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_0080);
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h12, 1'b1, 32'd0);

    // Multdiv to register 0: handshake completes, nothing is written.
    md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h55;
    tick();
    md_valid = 1'b0;
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h12, 1'b1, 32'd0);
    tick();
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h12, 1'b1, 32'd0);

    // Back-to-back offers: simultaneous push and pop keeps the count at 1.
    md_valid = 1'b1; md_reg = 5'd10; md_data = 32'hA;
    exp_wr(cyc + 2, 5'd10, 32'hA);
    exp_wr(cyc + 3, 5'd11, 32'hB);
    tick();
    md_reg = 5'd11; md_data = 32'hB;
    tick();
    md_valid = 1'b0;
    exp_st(3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA, 1'b1, 32'h0000_0800);
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'hB, 1'b1, 32'd0);

    // Fill under constant primary traffic, starve into STALL, one in-flight primary in STALL.
    for (int k = 0; k < 11; k++) begin
      wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hA000_0000 + k;
      exp_wr(cyc + 1, 5'd3, 32'hA000_0000 + k);
      if (k < 5) begin
        md_valid = 1'b1; md_reg = 5'(12 + k); md_data = 32'hC0 + k;
      end else begin
        md_valid = 1'b0;
      end
      tick();
      if (k == 3) exp_st(3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hA000_0003, 1'b1, 32'h0000_F000);
      if (k == 8) exp_st(3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hA000_0008, 1'b1, 32'h0000_F000);
      if (k == 9) exp_st(3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hA000_0009, 1'b1, 32'h0000_F000);
      if (k == 10) exp_st(3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hA000_000A, 1'b1, 32'h0000_F000);
    end
    md_valid = 1'b0;

    // Drain: four multdiv writes in acceptance order, stall drops a cycle after empty.
    wb_valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_wr(cyc + 1 + k, 5'(12 + k), 32'hC0 + k);
    tick();
    tick();
    tick();
    tick();
    exp_st(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd15, 32'hC3, 1'b1, 32'd0);
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 32'hC3, 1'b1, 32'd0);

    // Queue regs 4, 9, 4 behind primary traffic, then reset flushes them.
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'hB000_0000 + k;
      exp_wr(cyc + 1, 5'd2, 32'hB000_0000 + k);
      md_valid = 1'b1; md_reg = rr[k]; md_data = 32'hD0 + k;
      tick();
    end
    exp_st(3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'hB000_0002, 1'b1, 32'h0000_0210);
    ctrl_reset_n = 1'b0;
    wb_valid = 1'b0;
    md_valid = 1'b0;
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 32'd0);
    ctrl_reset_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    exp_st(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 32'd0);
    tick();
    done = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor_end got no summary want summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
